credit_sender: RTL and testbench

CREDIT_SENDER -- requirements
Module: credit_sender

---
 rtl/credit_pkg.sv | 12 +
 rtl/credit_counter.sv | 59 +++++
 rtl/credit_counter_checker.sv | 26 ++
 rtl/credit_sender.sv | 72 +++++++
 tb/tb_credit_sender.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/credit_pkg.sv
// Shared constants and width helper for the credit sender/receiver pair.
package credit_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_MAX_CREDIT = 4;

  // Counter width able to hold 0..max_credit inclusive.
  function automatic int credit_width(input int max_credit);
    return $clog2(max_credit + 1);
  endfunction

endpackage

// File: rtl/credit_counter.sv
// Saturating credit counter with load; shared by credit sender and receiver.
module credit_counter
  import credit_pkg::*;
#(
  parameter int  MAX_CREDIT = DEFAULT_MAX_CREDIT,
  localparam int CW         = credit_width(MAX_CREDIT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_value,
  input  logic          incr,
  input  logic          decr,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] MAX_COUNT = CW'(MAX_CREDIT);

  logic [CW-1:0] count_r;
  logic [CW-1:0] count_next_s;

  // Next count: load wins, then a lone increment or decrement, each clamped at its bound.
  always_comb begin
    count_next_s = count_r;
    if (load) begin
      count_next_s = load_value;
    end else begin
      case ({incr, decr})
        2'b10:   count_next_s = (count_r == MAX_COUNT) ? count_r : count_r + CW'(1);
        2'b01:   count_next_s = (count_r == {CW{1'b0}}) ? count_r : count_r - CW'(1);
        default: count_next_s = count_r;
      endcase
    end
  end

  // Counter register; reset takes the load value.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= load_value;
    end else begin
      count_r <= count_next_s;
    end
  end

  assign count = count_r;

  credit_counter_checker #(
    .MAX_CREDIT (MAX_CREDIT),
    .CW         (CW)
  ) u_checker (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .incr  (incr),
    .decr  (decr),
    .count (count_r)
  );

endmodule

// File: rtl/credit_counter_checker.sv
// Runtime checks on the credit counter: overflow is flagged, underflow must never happen.
module credit_counter_checker #(
  parameter int MAX_CREDIT = 4,
  parameter int CW         = 3
) (
  input logic          clk,
  input logic          rst,
  input logic          load,
  input logic          incr,
  input logic          decr,
  input logic [CW-1:0] count
);

  localparam logic [CW-1:0] MAX_COUNT = CW'(MAX_CREDIT);

  // Sample counter controls each edge and flag illegal credit arithmetic.
  always @(posedge clk) begin
    if (!rst && !load) begin
      assert (!(incr && !decr && (count == MAX_COUNT)))
        else $warning("credit_counter: credit returned while full, count saturated at %0d", MAX_CREDIT);
      assert (!(decr && !incr && (count == {CW{1'b0}})))
        else $error("credit_counter: credit consumed while count is zero");
    end
  end

endmodule

// File: rtl/credit_sender.sv
// Credit-based sender: gates upstream beats on available credit and registers them toward the receiver.
module credit_sender
  import credit_pkg::*;
#(
  parameter int  DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int  MAX_CREDIT = DEFAULT_MAX_CREDIT,
  localparam int CW         = credit_width(MAX_CREDIT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_valid,
  output logic                  push_ready,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  pop_valid,
  output logic [DATA_WIDTH-1:0] pop_data,
  input  logic                  pop_credit,
  output logic                  pop_sender_in_reset,
  input  logic                  pop_receiver_in_reset,
  input  logic [CW-1:0]         credit_initial,
  input  logic [CW-1:0]         credit_withhold,
  output logic [CW-1:0]         credit_count,
  output logic [CW-1:0]         credit_available
);

  logic [CW-1:0] count_s;
  logic [CW-1:0] available_s;
  logic          send_s;

  // Usable credit after the withheld reserve, floored at zero.
  always_comb begin
    available_s = {CW{1'b0}};
    if (count_s > credit_withhold) begin
      available_s = count_s - credit_withhold;
    end else begin
      available_s = {CW{1'b0}};
    end
  end

  // push_ready depends only on state and reset inputs, never on push_valid.
  assign push_ready          = (available_s != {CW{1'b0}}) & ~rst & ~pop_receiver_in_reset;
  assign send_s              = push_valid & push_ready;
  assign pop_sender_in_reset = rst;
  assign credit_count        = count_s;
  assign credit_available    = available_s;

  // Receiver reset reloads the counter every cycle and swallows returned credits.
  credit_counter #(
    .MAX_CREDIT (MAX_CREDIT)
  ) u_counter (
    .clk        (clk),
    .rst        (rst),
    .load       (pop_receiver_in_reset),
    .load_value (credit_initial),
    .incr       (pop_credit),
    .decr       (send_s),
    .count      (count_s)
  );

  // Single register stage toward the receiver; data holds when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      pop_valid <= 1'b0;
      pop_data  <= {DATA_WIDTH{1'b0}};
    end else begin
      pop_valid <= send_s;
      if (send_s) begin
        pop_data <= push_data;
      end
    end
  end

endmodule

// File: tb/tb_credit_sender.sv
// Directed bench for credit_sender: integer credit model checked every cycle plus literal scenario checks.
module tb_credit_sender;

  localparam int DW  = 8;
  localparam int MAX = 4;
  localparam int CW  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          push_valid;
  logic          push_ready;
  logic [DW-1:0] push_data;
  logic          pop_valid;
  logic [DW-1:0] pop_data;
  logic          pop_credit;
  logic          pop_sender_in_reset;
  logic          pop_receiver_in_reset;
  logic [CW-1:0] credit_initial;
  logic [CW-1:0] credit_withhold;
  logic [CW-1:0] credit_count;
  logic [CW-1:0] credit_available;

  int checks   = 0;
  int failures = 0;

  credit_sender #(.DATA_WIDTH(DW), .MAX_CREDIT(MAX)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .push_valid            (push_valid),
    .push_ready            (push_ready),
    .push_data             (push_data),
    .pop_valid             (pop_valid),
    .pop_data              (pop_data),
    .pop_credit            (pop_credit),
    .pop_sender_in_reset   (pop_sender_in_reset),
    .pop_receiver_in_reset (pop_receiver_in_reset),
    .credit_initial        (credit_initial),
    .credit_withhold       (credit_withhold),
    .credit_count          (credit_count),
    .credit_available      (credit_available)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: credits are a plain integer, the output stage a (valid, data) pair.
  int  m_count;
  bit  m_valid;
  int  m_data;
  bit  model_ok = 1'b0;

  function automatic int avail_of(input int count, input int withhold);
    return (count > withhold) ? count - withhold : 0;
  endfunction

  function automatic bit ready_of(input int count);
    return (avail_of(count, int'(credit_withhold)) != 0) && !rst && !pop_receiver_in_reset;
  endfunction

  always @(posedge clk) begin
    bit send;
    if (rst) begin
      m_count  = int'(credit_initial);
      m_valid  = 1'b0;
      m_data   = 0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      send    = push_valid && ready_of(m_count);
      m_valid = send;
      if (send) m_data = int'(push_data);
      if (pop_receiver_in_reset) begin
        m_count = int'(credit_initial);
      end else begin
        m_count = m_count + int'(pop_credit) - int'(send);
        if (m_count > MAX) m_count = MAX;
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("cyc pop_valid", int'(pop_valid), int'(m_valid));
      chk("cyc pop_data", int'(pop_data), m_data);
      chk("cyc credit_count", int'(credit_count), m_count);
      chk("cyc credit_available", int'(credit_available), avail_of(m_count, int'(credit_withhold)));
      chk("cyc push_ready", int'(push_ready), int'(ready_of(m_count)));
      chk("cyc pop_sender_in_reset", int'(pop_sender_in_reset), int'(rst));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; push_valid = 1'b0; push_data = 8'h00; pop_credit = 1'b0;
    pop_receiver_in_reset = 1'b0; credit_initial = 3'd2; credit_withhold = 3'd0;
    step(); step();
    #2;
    chk("rst push_ready", int'(push_ready), 0);
    chk("rst sender_in_reset", int'(pop_sender_in_reset), 1);
    chk("rst pop_valid", int'(pop_valid), 0);
    chk("rst pop_data", int'(pop_data), 0);
    chk("rst credit_count", int'(credit_count), 2);

    // Two credits, three beats offered.
    step(); rst = 1'b0; push_valid = 1'b1; push_data = 8'h11; #2;
    chk("s1 first ready", int'(push_ready), 1);
    step(); push_data = 8'h22; #2;
    chk("s1 count 1", int'(credit_count), 1);
    chk("s1 beat 11", int'(pop_data), 32'h11);
    chk("s1 valid 11", int'(pop_valid), 1);
    step(); push_data = 8'h33; #2;
    chk("s1 count 0", int'(credit_count), 0);
    chk("s1 beat 22", int'(pop_data), 32'h22);
    chk("s1 ready third", int'(push_ready), 0);
    step(); #2;
    chk("s1 no valid", int'(pop_valid), 0);
    chk("s1 data held", int'(pop_data), 32'h22);

    // Credit return releases a held beat.
    step(); push_data = 8'h44; pop_credit = 1'b1;
    step(); pop_credit = 1'b0; #2;
    chk("s2 count 1", int'(credit_count), 1);
    chk("s2 ready", int'(push_ready), 1);
    step(); push_valid = 1'b0; #2;
    chk("s2 beat 44", int'(pop_data), 32'h44);
    chk("s2 valid", int'(pop_valid), 1);
    chk("s2 count 0", int'(credit_count), 0);

    // Simultaneous send and credit return.
    step(); pop_credit = 1'b1;
    step(); push_valid = 1'b1; push_data = 8'h55; #2;
    chk("s3 count before", int'(credit_count), 1);
    step(); push_valid = 1'b0; pop_credit = 1'b0; #2;
    chk("s3 count same", int'(credit_count), 1);
    chk("s3 valid", int'(pop_valid), 1);
    chk("s3 beat 55", int'(pop_data), 32'h55);

    // Withhold takes effect combinationally.
    step(); pop_credit = 1'b1;
    step(); step(); pop_credit = 1'b0; #2;
    chk("s4 count 3", int'(credit_count), 3);
    credit_withhold = 3'd3; #2;
    chk("s4 ready wh3", int'(push_ready), 0);
    chk("s4 avail wh3", int'(credit_available), 0);
    credit_withhold = 3'd1; #2;
    chk("s4 avail wh1", int'(credit_available), 2);
    chk("s4 ready wh1", int'(push_ready), 1);
    chk("s4 count kept", int'(credit_count), 3);
    step(); credit_withhold = 3'd0;

    // Saturation at MAX_CREDIT.
    pop_credit = 1'b1;
    step(); #2;
    chk("s5 count max", int'(credit_count), 4);
    step(); pop_credit = 1'b0; #2;
    chk("s5 count sat", int'(credit_count), 4);

    // Reset and receiver reset in the middle of a stream.
    credit_initial = 3'd1; push_valid = 1'b1; push_data = 8'h66;
    step(); push_data = 8'h77;
    step(); rst = 1'b1; push_data = 8'h88; #2;
    chk("s6 ready in rst", int'(push_ready), 0);
    step(); rst = 1'b0; push_data = 8'h99; #2;
    chk("s6 valid after rst", int'(pop_valid), 0);
    chk("s6 count after rst", int'(credit_count), 1);
    chk("s6 ready after rst", int'(push_ready), 1);
    step(); pop_receiver_in_reset = 1'b1; pop_credit = 1'b1; push_data = 8'hAA; #2;
    chk("s6 beat 99", int'(pop_data), 32'h99);
    chk("s6 ready rir", int'(push_ready), 0);
    step(); #2;
    chk("s6 count rir", int'(credit_count), 1);
    chk("s6 valid rir", int'(pop_valid), 0);
    step(); pop_receiver_in_reset = 1'b0; pop_credit = 1'b0; #2;
    chk("s6 count post rir", int'(credit_count), 1);
    chk("s6 ready post rir", int'(push_ready), 1);
    step(); push_valid = 1'b0; #2;
    chk("s6 beat AA", int'(pop_data), 32'hAA);
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
